// File: rtl/segment_pkg.sv
// Shared types for the segment descriptor cache: register indices, decoded descriptor fields,
// load FSM states and the raw-descriptor decoder.
package segment_pkg;

  localparam int          DEFAULT_SEGMENT_COUNT = 6;
  localparam logic [31:0] DEFAULT_RESET_LIMIT   = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    SEG_ES = 3'd0,
    SEG_CS = 3'd1,
    SEG_SS = 3'd2,
    SEG_DS = 3'd3,
    SEG_FS = 3'd4,
    SEG_GS = 3'd5
  } segment_index_t;

  typedef struct packed {
    logic [31:0] base;
    logic [19:0] limit;
    logic        g;
    logic        b;
    logic        p;
    logic [1:0]  dpl;
    logic        s;
    logic [3:0]  seg_type;
  } descriptor_fields_t;

  typedef enum logic [1:0] {
    LOAD_IDLE,
    LOAD_DECODE,
    LOAD_COMMIT
  } load_state_t;

  // Bits 53:52 (AVL and L) carry nothing the cache needs.
  function automatic descriptor_fields_t decode_descriptor(input logic [63:0] d);
    descriptor_fields_t f;
    logic unused_avl;
    unused_avl = ^d[53:52];
    f.base     = {d[63:56], d[39:16]};
    f.limit    = {d[51:48], d[15:0]};
    f.g        = d[55];
    f.b        = d[54];
    f.p        = d[47];
    f.dpl      = d[46:45];
    f.s        = d[44];
    f.seg_type = d[43:40];
    return f;
  endfunction

endpackage

// File: rtl/segment_limit_checker.sv
// Combinational protection check for a single translation: presence, access rights and
// expand-up / expand-down limit bounds evaluated on the full byte range of the access.
module segment_limit_checker
  import segment_pkg::*;
(
  input  descriptor_fields_t fields,
  input  logic               index_valid,
  input  logic [31:0]        offset,
  input  logic [1:0]         size,
  input  logic               write,
  output logic               fault
);

  logic [31:0] eff_limit;
  logic [32:0] last_byte;
  logic [32:0] upper_bound;
  logic        is_code;
  logic        expand_down;
  logic        rights_fault;
  logic        limit_fault;
  logic        unused_fields;

  assign unused_fields = ^{fields.base, fields.dpl, fields.s};

  // The last byte is computed in 33 bits so an access straddling 4 GiB never wraps into range.
  always_comb begin
    eff_limit    = fields.g ? {fields.limit, 12'hFFF} : {12'h000, fields.limit};
    last_byte    = {1'b0, offset} + {31'b0, size};
    upper_bound  = fields.b ? 33'h0_FFFF_FFFF : 33'h0_0000_FFFF;
    is_code      = fields.seg_type[3];
    expand_down  = !is_code && fields.seg_type[2];
    rights_fault = is_code ? (write || !fields.seg_type[1]) : (write && !fields.seg_type[1]);
    if (expand_down) begin
      limit_fault = (offset <= eff_limit) || (last_byte > upper_bound);
    end else begin
      limit_fault = last_byte > {1'b0, eff_limit};
    end
    fault = !index_valid || !fields.p || rights_fault || limit_fault;
  end

endmodule

// File: rtl/segment_descriptor_cache.sv
// Hidden-part cache of the six segment registers: loads fetched GDT descriptors through a
// three-state FSM and serves registered segment+offset -> linear address translations.
module segment_descriptor_cache
  import segment_pkg::*;
#(
  parameter int          SEGMENT_COUNT = DEFAULT_SEGMENT_COUNT,
  parameter logic [31:0] RESET_LIMIT   = DEFAULT_RESET_LIMIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [2:0]  load_segment_index,
  input  logic [15:0] load_selector,
  input  logic [63:0] load_descriptor,
  output logic        load_done,
  output logic        load_fault,
  input  logic        translate_valid,
  output logic        translate_ready,
  input  logic [2:0]  translate_segment_index,
  input  logic [31:0] translate_offset,
  input  logic [1:0]  translate_size,
  input  logic        translate_write,
  output logic        result_valid,
  output logic [31:0] linear_address,
  output logic        translate_fault,
  output logic [15:0] selector_out
);

  localparam logic [2:0] LAST_INDEX = 3'(SEGMENT_COUNT - 1);
  localparam descriptor_fields_t RESET_FIELDS = '{
    base: 32'h0, limit: RESET_LIMIT[19:0], g: 1'b0, b: 1'b0,
    p: 1'b1, dpl: 2'b00, s: 1'b1, seg_type: 4'b0010
  };

  load_state_t        state;
  load_state_t        next_state;
  logic [2:0]         pend_index;
  logic [15:0]        pend_selector;
  logic [63:0]        pend_descriptor;
  descriptor_fields_t pend_fields;
  logic               pend_fault;
  descriptor_fields_t decoded;
  descriptor_fields_t entries [SEGMENT_COUNT];
  logic [15:0]        selectors [SEGMENT_COUNT];
  logic               load_accept;
  logic               translate_accept;
  logic               translate_index_valid;
  descriptor_fields_t translate_fields;
  logic               check_fault;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= LOAD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Translations are blocked while a load is in flight so they never see a half-updated entry.
  always_comb begin
    next_state      = state;
    load_ready      = 1'b0;
    translate_ready = 1'b0;
    case (state)
      LOAD_IDLE: begin
        load_ready      = 1'b1;
        translate_ready = 1'b1;
        if (load_valid) next_state = LOAD_DECODE;
      end
      LOAD_DECODE: next_state = LOAD_COMMIT;
      LOAD_COMMIT: next_state = LOAD_IDLE;
      default:     next_state = LOAD_IDLE;
    endcase
  end

  assign load_accept      = load_valid && load_ready;
  assign translate_accept = translate_valid && translate_ready;
  assign decoded          = decode_descriptor(pend_descriptor);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_index      <= '0;
      pend_selector   <= '0;
      pend_descriptor <= '0;
      pend_fields     <= RESET_FIELDS;
      pend_fault      <= 1'b0;
    end else begin
      if (load_accept) begin
        pend_index      <= load_segment_index;
        pend_selector   <= load_selector;
        pend_descriptor <= load_descriptor;
      end
      if (state == LOAD_DECODE) begin
        pend_fields <= decoded;
        pend_fault  <= (pend_index > LAST_INDEX) || !decoded.p || !decoded.s;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SEGMENT_COUNT; i++) begin
        entries[i]   <= RESET_FIELDS;
        selectors[i] <= '0;
      end
      load_done  <= 1'b0;
      load_fault <= 1'b0;
    end else begin
      load_done  <= (state == LOAD_COMMIT);
      load_fault <= (state == LOAD_COMMIT) && pend_fault;
      if ((state == LOAD_COMMIT) && !pend_fault) begin
        entries[pend_index]   <= pend_fields;
        selectors[pend_index] <= pend_selector;
      end
    end
  end

  // An out-of-range index reads the reset entry with a zero base; the checker faults it regardless.
  assign translate_index_valid = translate_segment_index <= LAST_INDEX;
  assign translate_fields = translate_index_valid ? entries[translate_segment_index] : RESET_FIELDS;
  assign selector_out     = translate_index_valid ? selectors[translate_segment_index] : 16'h0000;

  segment_limit_checker u_limit_checker (
    .fields      (translate_fields),
    .index_valid (translate_index_valid),
    .offset      (translate_offset),
    .size        (translate_size),
    .write       (translate_write),
    .fault       (check_fault)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_valid    <= 1'b0;
      linear_address  <= '0;
      translate_fault <= 1'b0;
    end else begin
      result_valid <= translate_accept;
      if (translate_accept) begin
        linear_address  <= translate_fields.base + translate_offset;
        translate_fault <= check_fault;
      end
    end
  end

endmodule

// File: tb/tb_segment_descriptor_cache.sv
// Self-checking bench for segment_descriptor_cache: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural segment model.
module tb_segment_descriptor_cache;
  import segment_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [2:0]  load_segment_index;
  logic [15:0] load_selector;
  logic [63:0] load_descriptor;
  logic        load_done;
  logic        load_fault;
  logic        translate_valid;
  logic        translate_ready;
  logic [2:0]  translate_segment_index;
  logic [31:0] translate_offset;
  logic [1:0]  translate_size;
  logic        translate_write;
  logic        result_valid;
  logic [31:0] linear_address;
  logic        translate_fault;
  logic [15:0] selector_out;

  segment_descriptor_cache dut (
    .clock                   (clock),
    .reset                   (reset),
    .load_valid              (load_valid),
    .load_ready              (load_ready),
    .load_segment_index      (load_segment_index),
    .load_selector           (load_selector),
    .load_descriptor         (load_descriptor),
    .load_done               (load_done),
    .load_fault              (load_fault),
    .translate_valid         (translate_valid),
    .translate_ready         (translate_ready),
    .translate_segment_index (translate_segment_index),
    .translate_offset        (translate_offset),
    .translate_size          (translate_size),
    .translate_write         (translate_write),
    .result_valid            (result_valid),
    .linear_address          (linear_address),
    .translate_fault         (translate_fault),
    .selector_out            (selector_out)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Behavioural model: per-segment base, effective byte limit, flags and selector.
  logic [31:0] m_base [6];
  logic [31:0] m_elim [6];
  logic        m_b    [6];
  logic        m_p    [6];
  logic [3:0]  m_type [6];
  logic [15:0] m_sel  [6];

  typedef struct {
    int          due;
    logic [2:0]  idx;
    logic [15:0] sel;
    logic [63:0] desc;
  } pending_t;

  pending_t    pend_q[$];
  int          busy = 0;
  logic        exp_rv = 1'b0;
  logic        exp_tf = 1'b0;
  logic        exp_addr_known = 1'b0;
  logic [31:0] exp_la = '0;

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin
      m_base[i] = 32'h0;
      m_elim[i] = 32'h0000_FFFF;
      m_b[i]    = 1'b0;
      m_p[i]    = 1'b1;
      m_type[i] = 4'b0010;
      m_sel[i]  = 16'h0;
    end
    pend_q.delete();
    busy   = 0;
    exp_rv = 1'b0;
  endfunction

  function automatic logic model_commit(input pending_t pd);
    logic [63:0] d;
    logic [31:0] lim;
    d = pd.desc;
    if (pd.idx > 3'd5 || !d[47] || !d[44]) return 1'b1;
    lim = {12'h0, d[51:48], d[15:0]};
    m_base[pd.idx] = {d[63:56], d[39:16]};
    m_elim[pd.idx] = d[55] ? (lim * 32'd4096 + 32'd4095) : lim;
    m_b[pd.idx]    = d[54];
    m_p[pd.idx]    = d[47];
    m_type[pd.idx] = d[43:40];
    m_sel[pd.idx]  = pd.sel;
    return 1'b0;
  endfunction

  // Legal byte range is [0, limit] for expand-up and (limit, top] for expand-down data.
  function automatic logic model_fault(input logic [2:0] idx, input logic [31:0] off,
                                       input logic [1:0] size, input logic wr);
    longint unsigned first_b;
    longint unsigned last_b;
    longint unsigned top;
    logic code;
    if (idx > 3'd5) return 1'b1;
    if (!m_p[idx]) return 1'b1;
    code = m_type[idx][3];
    if (code && (wr || !m_type[idx][1])) return 1'b1;
    if (!code && wr && !m_type[idx][1]) return 1'b1;
    first_b = off;
    last_b  = first_b + size;
    if (!code && m_type[idx][2]) begin
      top = m_b[idx] ? 64'hFFFF_FFFF : 64'h0000_FFFF;
      return (first_b <= m_elim[idx]) || (last_b > top);
    end
    return last_b > m_elim[idx];
  endfunction

  always @(negedge clock) begin
    logic ready_now;
    logic exp_done;
    logic exp_lfault;
    if (reset) begin
      model_reset();
    end else begin
      cycle++;
      exp_done   = 1'b0;
      exp_lfault = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == cycle) begin
        exp_done   = 1'b1;
        exp_lfault = model_commit(pend_q.pop_front());
      end
      ready_now = (busy == 0);
      check_output("load_done", load_done, exp_done);
      if (exp_done) check_output("load_fault", load_fault, exp_lfault);
      check_output("load_ready", load_ready, ready_now);
      check_output("translate_ready", translate_ready, ready_now);
      check_output("result_valid", result_valid, exp_rv);
      if (exp_rv) begin
        check_output("translate_fault", translate_fault, exp_tf);
        if (exp_addr_known) check_output("linear_address", linear_address, exp_la);
      end
      if (translate_segment_index <= 3'd5)
        check_output("selector_out", selector_out, m_sel[translate_segment_index]);
      if (busy > 0) busy--;
      exp_rv = translate_valid && ready_now;
      if (exp_rv) begin
        exp_addr_known = translate_segment_index <= 3'd5;
        exp_la = exp_addr_known ? m_base[translate_segment_index] + translate_offset : 32'h0;
        exp_tf = model_fault(translate_segment_index, translate_offset, translate_size, translate_write);
      end
      if (load_valid && ready_now) begin
        pending_t pd;
        pd.due  = cycle + 3;
        pd.idx  = load_segment_index;
        pd.sel  = load_selector;
        pd.desc = load_descriptor;
        pend_q.push_back(pd);
        busy = 2;
      end
    end
  end

  task automatic apply_translate(input logic [2:0] idx, input logic [31:0] off, input logic [1:0] size,
                                 input logic wr, input logic [31:0] exp_addr, input logic exp_fault,
                                 input string name);
    int waited = 0;
    @(posedge clock); #1;
    translate_valid         = 1'b1;
    translate_segment_index = idx;
    translate_offset        = off;
    translate_size          = size;
    translate_write         = wr;
    @(negedge clock);
    while (!translate_ready && waited < 20) begin
      waited++;
      @(negedge clock);
    end
    check_output({name, " accepted"}, translate_ready, 1'b1);
    @(posedge clock); #1;
    translate_valid = 1'b0;
    @(negedge clock);
    check_output({name, " valid"}, result_valid, 1'b1);
    check_output({name, " fault"}, translate_fault, exp_fault);
    if (idx <= 3'd5) check_output({name, " addr"}, linear_address, exp_addr);
  endtask

  task automatic apply_load(input logic [2:0] idx, input logic [15:0] sel, input logic [63:0] desc,
                            input logic exp_fault, input string name);
    int waited = 0;
    int lat = 0;
    @(posedge clock); #1;
    load_valid         = 1'b1;
    load_segment_index = idx;
    load_selector      = sel;
    load_descriptor    = desc;
    @(negedge clock);
    while (!load_ready && waited < 20) begin
      waited++;
      @(negedge clock);
    end
    check_output({name, " accepted"}, load_ready, 1'b1);
    @(posedge clock); #1;
    load_valid = 1'b0;
    do begin
      @(negedge clock);
      lat++;
    end while (!load_done && lat < 10);
    check_output({name, " done latency"}, 64'(lat), 64'd3);
    check_output({name, " load_fault"}, load_fault, exp_fault);
  endtask

  task automatic apply_stimulus_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] d;
      logic [2:0]  ti;
      @(posedge clock); #1;
      d = {$urandom, $urandom};
      d[47] = ($urandom_range(0, 7) != 0);
      d[44] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) d[51:48] = 4'h0;
      if ($urandom_range(0, 1) == 1) d[55] = 1'b0;
      load_valid         = ($urandom_range(0, 3) == 0);
      load_segment_index = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      load_selector      = 16'($urandom);
      load_descriptor    = d;
      ti = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      translate_valid         = ($urandom_range(0, 1) == 1);
      translate_segment_index = ti;
      case ($urandom_range(0, 3))
        0: translate_offset = $urandom;
        1: translate_offset = (ti <= 3'd5) ? m_elim[ti] + 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
        2: translate_offset = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        default: translate_offset = 32'h0000_FFFF + 32'($urandom_range(0, 4)) - 32'd2;
      endcase
      translate_size  = 2'($urandom_range(0, 3));
      translate_write = ($urandom_range(0, 1) == 1);
    end
    @(posedge clock); #1;
    load_valid      = 1'b0;
    translate_valid = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stall;
    int done_seen;
    reset = 1'b1;
    load_valid = 1'b0; load_segment_index = '0; load_selector = '0; load_descriptor = '0;
    translate_valid = 1'b0; translate_segment_index = 3'(SEG_DS); translate_offset = '0;
    translate_size = '0; translate_write = 1'b0;
    repeat (2) @(negedge clock);
    check_output("reset load_ready", load_ready, 1'b1);
    check_output("reset translate_ready", translate_ready, 1'b1);
    check_output("reset load_done", load_done, 1'b0);
    check_output("reset load_fault", load_fault, 1'b0);
    check_output("reset result_valid", result_valid, 1'b0);
    check_output("reset linear_address", linear_address, 32'h0);
    check_output("reset translate_fault", translate_fault, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    apply_translate(3'(SEG_DS), 32'h0000_FFFF, 2'd0, 1'b0, 32'h0000_FFFF, 1'b0, "reset DS at limit");
    apply_translate(3'(SEG_DS), 32'h0001_0000, 2'd0, 1'b0, 32'h0001_0000, 1'b1, "reset DS past limit");

    apply_load(3'(SEG_DS), 16'h0010, 64'h00CF_9200_0000_FFFF, 1'b0, "load DS flat");
    apply_translate(3'(SEG_DS), 32'hFFFF_FFFC, 2'd3, 1'b1, 32'hFFFF_FFFC, 1'b0, "DS top dword write");
    apply_translate(3'(SEG_DS), 32'hFFFF_FFFD, 2'd3, 1'b0, 32'hFFFF_FFFD, 1'b1, "DS dword over 4G");

    apply_load(3'(SEG_CS), 16'h0008, 64'h0040_9A12_3400_0FFF, 1'b0, "load CS");
    apply_translate(3'(SEG_CS), 32'h0000_0010, 2'd0, 1'b0, 32'h0012_3410, 1'b0, "CS read");
    apply_translate(3'(SEG_CS), 32'h0000_0010, 2'd0, 1'b1, 32'h0012_3410, 1'b1, "CS write");
    check_output("CS selector", selector_out, 16'h0008);
    apply_load(3'(SEG_CS), 16'h0020, 64'h0040_1A55_0000_0FFF, 1'b1, "load CS not present");
    apply_translate(3'(SEG_CS), 32'h0000_0010, 2'd0, 1'b0, 32'h0012_3410, 1'b0, "CS kept after fault");
    check_output("CS selector kept", selector_out, 16'h0008);
    apply_load(3'd7, 16'h0030, 64'h00CF_9200_0000_FFFF, 1'b1, "load bad index");
    apply_translate(3'd6, 32'h0000_0000, 2'd0, 1'b0, 32'h0, 1'b1, "translate bad index");

    apply_load(3'(SEG_SS), 16'h0018, 64'h0040_9600_0000_0FFF, 1'b0, "load SS expand-down");
    apply_translate(3'(SEG_SS), 32'h0000_0FFF, 2'd0, 1'b0, 32'h0000_0FFF, 1'b1, "SS at limit");
    apply_translate(3'(SEG_SS), 32'h0000_1000, 2'd0, 1'b1, 32'h0000_1000, 1'b0, "SS above limit");
    apply_translate(3'(SEG_SS), 32'hFFFF_FFFE, 2'd3, 1'b0, 32'hFFFF_FFFE, 1'b1, "SS over top");

    @(posedge clock); #1;
    load_valid = 1'b1; load_segment_index = 3'(SEG_ES); load_selector = 16'h0028;
    load_descriptor = 64'h0040_92AB_C000_FFFF;
    @(posedge clock); #1;
    load_valid = 1'b0;
    translate_valid = 1'b1; translate_segment_index = 3'(SEG_ES); translate_offset = 32'h10;
    translate_size = 2'd0; translate_write = 1'b0;
    stall = 0;
    @(negedge clock);
    while (!translate_ready && stall < 10) begin
      stall++;
      @(negedge clock);
    end
    check_output("hazard stall cycles", 64'(stall), 64'd2);
    @(posedge clock); #1;
    translate_valid = 1'b0;
    @(negedge clock);
    check_output("hazard result valid", result_valid, 1'b1);
    check_output("hazard new base", linear_address, 32'h00AB_C010);

    @(posedge clock); #1;
    load_valid = 1'b1; load_segment_index = 3'(SEG_ES); load_selector = 16'h0038;
    load_descriptor = 64'h0040_9255_0000_FFFF;
    @(posedge clock); #1;
    load_valid = 1'b0;
    reset = 1'b1;
    done_seen = 0;
    repeat (2) begin
      @(negedge clock);
      done_seen += int'(load_done);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      done_seen += int'(load_done);
    end
    check_output("reset mid-load done pulses", 64'(done_seen), 64'd0);
    apply_translate(3'(SEG_ES), 32'h0000_0010, 2'd0, 1'b0, 32'h0000_0010, 1'b0, "ES base after reset");
    apply_translate(3'(SEG_ES), 32'h0001_0000, 2'd0, 1'b0, 32'h0001_0000, 1'b1, "ES limit after reset");

    apply_stimulus_random(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
